sipo_rx_ctrl: RTL and testbench

Serial-frame receive controller that sequences a SIPO shift register with clock-enable. An internal prescaler generates mid-bit sample ticks. A framing FSM detects the start bit, enables exactly WIDTH shifts, checks the stop bit, and then hands the word off over a VALID/READY handshake. It sits between a board input pin and downstream parallel logic (e.g. LED/J3 drivers) in icestick designs.

---
 rtl/sipo_rx_ctrl_pkg.sv | 21 ++
 rtl/sipo_ce.sv | 36 +++
 rtl/sipo_rx_ctrl.sv | 151 +++++++++++++++
 tb/tb_sipo_rx_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_rx_ctrl_pkg.sv
// Shared types and width helpers for the serial-frame receive controller.
package sipo_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // Bits needed to hold values 0..n-1 (minimum 1).
    function automatic int unsigned cw_of(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sipo_ce.sv
// WIDTH-bit right-shift register with clock enable; serial data enters the MSB.
module sipo_ce #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce_i,
    input  logic             si_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (ce_i) begin
            if (WIDTH == 1) begin
                shift_d = WIDTH'(si_i);
            end else begin
                shift_d = {si_i, shift_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign q_o = shift_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Serial-frame receiver: start detect, mid-bit sampling prescaler, WIDTH-bit
// SIPO capture, stop check and VALID/READY hand-off of the received word.
module sipo_rx_ctrl
    import sipo_rx_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             I,
    output logic [WIDTH-1:0] O,
    output logic             VALID,
    input  logic             READY,
    output logic             FERR,
    output logic             OVR,
    output logic             BUSY
);

    localparam int unsigned CW = cw_of(DIV);
    localparam int unsigned BW = cw_of(WIDTH + 1);

    logic [1:0]       sync_q;
    logic             sin;
    state_e           state_q, state_d;
    logic [CW-1:0]    presc_q, presc_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;
    logic             tick_c;
    logic             shift_ce_c;
    logic [WIDTH-1:0] shift_word;

    // Synchroniser resets to the idle level so release never looks like a start bit.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], I};
        end
    end

    assign sin = sync_q[1];

    sipo_ce #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk  (CLK),
        .rst_n(RESETN),
        .ce_i (shift_ce_c),
        .si_i (sin),
        .q_o  (shift_word)
    );

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        bitcnt_d   = bitcnt_q;
        data_d     = data_q;
        valid_d    = valid_q & ~READY;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        shift_ce_c = 1'b0;
        tick_c     = (state_q != ST_IDLE) && (presc_q == '0);

        if (state_q != ST_IDLE) begin
            presc_d = tick_c ? CW'(DIV - 1) : presc_q - CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!sin) begin
                    presc_d = CW'(DIV / 2 - 1);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    if (!sin) begin
                        bitcnt_d = '0;
                        state_d  = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    shift_ce_c = 1'b1;
                    bitcnt_d   = bitcnt_q + BW'(1);
                    if (bitcnt_q == BW'(WIDTH - 1)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // A load on an accepting edge keeps VALID high with the new word.
                if (tick_c) begin
                    state_d = ST_IDLE;
                    if (sin) begin
                        if (!valid_q || READY) begin
                            data_d  = shift_word;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            bitcnt_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            bitcnt_q <= bitcnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
            busy_q   <= busy_d;
        end
    end

    assign O     = data_q;
    assign VALID = valid_q;
    assign FERR  = ferr_q;
    assign OVR   = ovr_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Scoreboard bench for sipo_rx_ctrl (WIDTH=4, DIV=8): frames drive expected
// words into a queue, a negedge monitor pops them on each VALID&READY accept.
module tb_sipo_rx_ctrl;

    localparam int WIDTH = 4;
    localparam int DIV   = 8;
    localparam int FCYC  = (WIDTH + 2) * DIV;

    logic             CLK;
    logic             RESETN;
    logic             I;
    logic             READY;
    logic [WIDTH-1:0] O;
    logic             VALID;
    logic             FERR;
    logic             OVR;
    logic             BUSY;

    int n_tests;
    int n_fail;

    logic [WIDTH-1:0] exp_q[$];
    logic             busy_h [1:FCYC];
    logic             valid_h[1:FCYC];
    logic             ferr_h [1:FCYC];
    logic             ovr_h  [1:FCYC];
    logic [WIDTH-1:0] o_h    [1:FCYC];

    sipo_rx_ctrl #(
        .WIDTH(WIDTH),
        .DIV  (DIV)
    ) dut (
        .CLK   (CLK),
        .RESETN(RESETN),
        .I     (I),
        .O     (O),
        .VALID (VALID),
        .READY (READY),
        .FERR  (FERR),
        .OVR   (OVR),
        .BUSY  (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    function automatic int cnt(input logic h[1:FCYC]);
        int s;
        s = 0;
        for (int e = 1; e <= FCYC; e++) if (h[e] === 1'b1) s++;
        return s;
    endfunction

    // Drives one frame period cycle by cycle and records outputs after each edge.
    // Edge 3 is the start-detect edge k; edge 47 is the stop sample k+44.
    task automatic drive_frame(input logic [WIDTH-1:0] d, input logic stop, input bit glitch,
                               input logic rdy_base, input int rdy_edge, input int rst_edge);
        for (int e = 1; e <= FCYC; e++) begin
            int c;
            c = e - 1;
            if (glitch)                    I = (c < 2) ? 1'b0 : 1'b1;
            else if (c < DIV)              I = 1'b0;
            else if (c < (WIDTH + 1) * DIV) I = d[(c / DIV) - 1];
            else                           I = stop;
            READY = (e == rdy_edge) ? 1'b1 : rdy_base;
            @(posedge CLK);
            #2;
            busy_h[e]  = BUSY;
            valid_h[e] = VALID;
            ferr_h[e]  = FERR;
            ovr_h[e]   = OVR;
            o_h[e]     = O;
            if (e == rst_edge) begin
                RESETN = 1'b0;
                #1;
                n_tests++;
                if ({O, VALID, FERR, OVR, BUSY} !== '0) begin
                    n_fail++;
                    $display("FAIL mid_reset_outs: O=%h V=%b FE=%b OV=%b B=%b required all 0",
                             O, VALID, FERR, OVR, BUSY);
                end
            end
        end
        I     = 1'b1;
        READY = rdy_base;
    endtask

    task automatic drain_one();
        READY = 1'b1;
        cyc(1);
        READY = 1'b0;
        n_tests++;
        if (VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_valid: VALID=%b required 0", VALID);
        end
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        I      = 1'b1;
        READY  = 1'b0;
        cyc(3);
        n_tests++;
        if ({O, VALID, FERR, OVR, BUSY} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: O=%h V=%b FE=%b OV=%b B=%b required all 0",
                     O, VALID, FERR, OVR, BUSY);
        end
        RESETN = 1'b1;
        cyc(100);
        n_tests++;
        if ({VALID, FERR, OVR, BUSY} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_outs: V=%b FE=%b OV=%b B=%b required 0000", VALID, FERR, OVR, BUSY);
        end
    endtask

    task automatic test_frame_hold();
        exp_q.push_back(4'hA);
        drive_frame(4'hA, 1'b1, 1'b0, 1'b0, 0, 0);
        n_tests++;
        if (busy_h[2] !== 1'b0 || busy_h[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL start_detect: busy@2=%b busy@3=%b required 0,1", busy_h[2], busy_h[3]);
        end
        n_tests++;
        if (valid_h[46] !== 1'b0 || valid_h[48] !== 1'b1) begin
            n_fail++;
            $display("FAIL valid_timing: v@k+43=%b v@k+45=%b required 0,1", valid_h[46], valid_h[48]);
        end
        n_tests++;
        if (o_h[48] !== 4'hA) begin
            n_fail++;
            $display("FAIL frame_a_word: O=%h required a", o_h[48]);
        end
        cyc(10);
        n_tests++;
        if (VALID !== 1'b1 || O !== 4'hA) begin
            n_fail++;
            $display("FAIL frame_a_hold: V=%b O=%h required 1,a", VALID, O);
        end
        drain_one();
    endtask

    task automatic test_glitch();
        drive_frame(4'h0, 1'b1, 1'b1, 1'b0, 0, 0);
        n_tests++;
        if (busy_h[3] !== 1'b1 || busy_h[6] !== 1'b1 || busy_h[7] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy: b@3=%b b@6=%b b@7=%b required 1,1,0",
                     busy_h[3], busy_h[6], busy_h[7]);
        end
        n_tests++;
        if (cnt(valid_h) != 0 || cnt(ferr_h) != 0 || cnt(ovr_h) != 0) begin
            n_fail++;
            $display("FAIL glitch_quiet: valid=%0d ferr=%0d ovr=%0d cycles required 0",
                     cnt(valid_h), cnt(ferr_h), cnt(ovr_h));
        end
    endtask

    task automatic test_framing_error();
        drive_frame(4'h3, 1'b0, 1'b0, 1'b0, 0, 0);
        n_tests++;
        if (ferr_h[47] !== 1'b1 || cnt(ferr_h) != 1) begin
            n_fail++;
            $display("FAIL ferr_pulse: ferr@k+44=%b pulses=%0d required 1,1", ferr_h[47], cnt(ferr_h));
        end
        n_tests++;
        if (cnt(valid_h) != 0 || O !== 4'hA) begin
            n_fail++;
            $display("FAIL ferr_no_word: valid=%0d O=%h required 0,a", cnt(valid_h), O);
        end
    endtask

    task automatic test_overrun();
        exp_q.push_back(4'h5);
        drive_frame(4'h5, 1'b1, 1'b0, 1'b0, 0, 0);
        drive_frame(4'hC, 1'b1, 1'b0, 1'b0, 0, 0);
        n_tests++;
        if (ovr_h[47] !== 1'b1 || cnt(ovr_h) != 1) begin
            n_fail++;
            $display("FAIL ovr_pulse: ovr@k+44=%b pulses=%0d required 1,1", ovr_h[47], cnt(ovr_h));
        end
        n_tests++;
        if (VALID !== 1'b1 || O !== 4'h5) begin
            n_fail++;
            $display("FAIL ovr_keep: V=%b O=%h required 1,5", VALID, O);
        end
        drain_one();
    endtask

    task automatic test_accept_on_load();
        exp_q.push_back(4'h5);
        drive_frame(4'h5, 1'b1, 1'b0, 1'b0, 0, 0);
        exp_q.push_back(4'hC);
        drive_frame(4'hC, 1'b1, 1'b0, 1'b0, 47, 0);
        n_tests++;
        if (cnt(ovr_h) != 0 || cnt(valid_h) != FCYC) begin
            n_fail++;
            $display("FAIL load_accept_flags: ovr=%0d valid=%0d cycles required 0,%0d",
                     cnt(ovr_h), cnt(valid_h), FCYC);
        end
        n_tests++;
        if (o_h[47] !== 4'hC || VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL load_accept_word: O=%h V=%b required c,1", o_h[47], VALID);
        end
        drain_one();
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(4'h9);
        drive_frame(4'h9, 1'b1, 1'b0, 1'b1, 0, 0);
        exp_q.push_back(4'h4);
        drive_frame(4'h4, 1'b1, 1'b0, 1'b1, 0, 0);
        cyc(2);
        READY = 1'b0;
        n_tests++;
        if (cnt(ovr_h) != 0 || VALID !== 1'b0 || O !== 4'h4) begin
            n_fail++;
            $display("FAIL b2b_final: ovr=%0d V=%b O=%h required 0,0,4", cnt(ovr_h), VALID, O);
        end
    endtask

    task automatic test_mid_reset();
        drive_frame(4'h6, 1'b1, 1'b0, 1'b0, 0, 28);
        RESETN = 1'b1;
        cyc(4);
        n_tests++;
        if ({O, VALID, BUSY} !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: O=%h V=%b B=%b required 0,0,0", O, VALID, BUSY);
        end
        exp_q.push_back(4'h6);
        drive_frame(4'h6, 1'b1, 1'b0, 1'b0, 0, 0);
        n_tests++;
        if (o_h[48] !== 4'h6 || valid_h[48] !== 1'b1 || cnt(ferr_h) != 0) begin
            n_fail++;
            $display("FAIL post_reset_frame: O=%h V=%b ferr=%0d required 6,1,0",
                     o_h[48], valid_h[48], cnt(ferr_h));
        end
        drain_one();
    endtask

    initial begin
        logic             pv;
        logic             pacc;
        logic [WIDTH-1:0] po;
        logic [WIDTH-1:0] exp_w;
        n_tests = 0;
        n_fail  = 0;
        pv      = 1'b0;
        pacc    = 1'b0;
        po      = '0;
        RESETN  = 1'b0;
        I       = 1'b1;
        READY   = 1'b0;

        fork
            forever begin
                @(negedge CLK);
                if (RESETN !== 1'b1) begin
                    pv = 1'b0;
                end else begin
                    if (pv && !pacc && VALID === 1'b1) begin
                        n_tests++;
                        if (O !== po) begin
                            n_fail++;
                            $display("FAIL o_stable: O=%h required %h", O, po);
                        end
                    end
                    if (VALID === 1'b1 && READY === 1'b1) begin
                        n_tests++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL sb_unexpected: O=%h required no word", O);
                        end else begin
                            exp_w = exp_q.pop_front();
                            if (O !== exp_w) begin
                                n_fail++;
                                $display("FAIL sb_word: O=%h required %h", O, exp_w);
                            end
                        end
                    end
                    pv   = VALID;
                    pacc = VALID && READY;
                    po   = O;
                end
            end
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        test_reset();
        test_frame_hold();
        test_glitch();
        test_framing_error();
        test_overrun();
        test_accept_on_load();
        test_back_to_back();
        test_mid_reset();

        cyc(4);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d words pending required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
